// File: rtl/trace_capture.sv
// Circular trace buffer: snapshots PC and probe registers each valid cycle, stops a
// programmable number of samples after a trigger, and offers registered indexed readback.
module trace_capture #(
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned CHANNELS = 6,
    parameter  int unsigned DEPTH    = 32,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       trigger,
    input  logic                       valid,
    input  logic [DATA_W-1:0]          pc,
    input  logic [CHANNELS*DATA_W-1:0] probe,
    input  logic [AW-1:0]              post_count,
    input  logic [AW-1:0]              rd_index,
    input  logic [3:0]                 rd_chan,
    output logic [DATA_W-1:0]          rd_data,
    output logic [31:0]                rd_cycle,
    output logic [AW:0]                count,
    output logic [AW-1:0]              trig_index,
    output logic [1:0]                 state,
    output logic                       done
);
    localparam int unsigned EntryW = 32 + DATA_W + CHANNELS * DATA_W;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StArmed = 2'b01,
        StPost  = 2'b10,
        StDone  = 2'b11
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW:0]     count_q;
    logic [31:0]     cycle_q;
    logic [AW-1:0]   remaining_q;
    logic [AW-1:0]   trig_slot_q;
    logic            trig_hit_q;
    logic            wr_en;
    logic [AW-1:0]   oldest;
    logic [AW-1:0]   rd_slot;
    logic            rd_hit;
    logic [EntryW-1:0]          entry;
    logic [31:0]                ent_cycle;
    logic [DATA_W-1:0]          ent_pc;
    logic [CHANNELS*DATA_W-1:0] ent_probe;
    logic [DATA_W-1:0]          field;

    logic [EntryW-1:0] mem [DEPTH];

    // arm takes priority over any sample presented in the same cycle
    assign wr_en = valid && !arm && (state_q == StArmed || state_q == StPost);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            cycle_q     <= '0;
            remaining_q <= '0;
            trig_slot_q <= '0;
            trig_hit_q  <= 1'b0;
        end else if (arm) begin
            state_q     <= StArmed;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            cycle_q     <= '0;
            remaining_q <= '0;
            trig_slot_q <= '0;
            trig_hit_q  <= 1'b0;
        end else begin
            case (state_q)
                StArmed: begin
                    cycle_q <= cycle_q + 32'd1;
                    if (valid) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        if (!count_q[AW]) count_q <= count_q + (AW+1)'(1);
                        if (trigger) begin
                            trig_slot_q <= wr_ptr_q;
                            trig_hit_q  <= 1'b1;
                            remaining_q <= post_count;
                            state_q     <= (post_count == '0) ? StDone : StPost;
                        end
                    end
                end
                StPost: begin
                    cycle_q <= cycle_q + 32'd1;
                    if (valid) begin
                        wr_ptr_q    <= wr_ptr_q + AW'(1);
                        remaining_q <= remaining_q - AW'(1);
                        if (!count_q[AW]) count_q <= count_q + (AW+1)'(1);
                        if (remaining_q == AW'(1)) state_q <= StDone;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= {cycle_q, pc, probe};
    end

    // count saturates at DEPTH, so its top bit alone marks a wrapped buffer
    assign oldest     = count_q[AW] ? wr_ptr_q : '0;
    assign rd_slot    = oldest + rd_index;
    assign trig_index = trig_hit_q ? (trig_slot_q - oldest) : '0;
    assign rd_hit     = ({1'b0, rd_index} < count_q) && (32'(rd_chan) <= CHANNELS);

    assign entry     = mem[rd_slot];
    assign ent_cycle = entry[EntryW-1 -: 32];
    assign ent_pc    = entry[CHANNELS*DATA_W +: DATA_W];
    assign ent_probe = entry[CHANNELS*DATA_W-1:0];

    always_comb begin
        field = ent_pc;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (32'(rd_chan) == k + 1) field = ent_probe[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_cycle <= '0;
        end else if (rd_hit) begin
            rd_data  <= field;
            rd_cycle <= ent_cycle;
        end else begin
            rd_data  <= '0;
            rd_cycle <= '0;
        end
    end

    assign count = count_q;
    assign state = state_q;
    assign done  = (state_q == StDone);

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture (DEPTH=8, CHANNELS=2): capture scenarios followed by
// table-driven readback checks against hand-computed entries.
module tb_trace_capture;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned DEPTH    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        trigger;
    logic        valid;
    logic [31:0] pc;
    logic [63:0] probe;
    logic [2:0]  post_count;
    logic [2:0]  rd_index;
    logic [3:0]  rd_chan;
    logic [31:0] rd_data;
    logic [31:0] rd_cycle;
    logic [3:0]  count;
    logic [2:0]  trig_index;
    logic [1:0]  state;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  idx;
        logic [3:0]  chan;
        logic [31:0] data;
        logic [31:0] cyc;
    } rd_vec_t;

    rd_vec_t rv [8];
    int      nrv;

    trace_capture #(
        .DATA_W  (DATA_W),
        .CHANNELS(CHANNELS),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .trigger   (trigger),
        .valid     (valid),
        .pc        (pc),
        .probe     (probe),
        .post_count(post_count),
        .rd_index  (rd_index),
        .rd_chan   (rd_chan),
        .rd_data   (rd_data),
        .rd_cycle  (rd_cycle),
        .count     (count),
        .trig_index(trig_index),
        .state     (state),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [31:0] p, input logic v, input logic t);
        pc      = p;
        probe   = {p + 32'h2000, p + 32'h1000};
        valid   = v;
        trigger = t;
        tick();
        valid   = 1'b0;
        trigger = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [1:0] st, input logic [3:0] cnt,
                                input logic [2:0] ti);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".count"}, 32'(count), 32'(cnt));
        check({tag, ".trig_index"}, 32'(trig_index), 32'(ti));
        check({tag, ".done"}, 32'(done), 32'(st == 2'b11));
    endtask

    task automatic apply_reads(input string tag);
        for (int i = 0; i < nrv; i++) begin
            rd_index = rv[i].idx;
            rd_chan  = rv[i].chan;
            tick();
            check($sformatf("%s.rd_data[%0d]", tag, i), rd_data, rv[i].data);
            check($sformatf("%s.rd_cycle[%0d]", tag, i), rd_cycle, rv[i].cyc);
        end
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; trigger = 1'b0; valid = 1'b0;
        pc = '0; probe = '0; post_count = '0; rd_index = '0; rd_chan = '0;
        tick();
        tick();
        check("reset.rd_data", rd_data, 32'h0);
        check("reset.rd_cycle", rd_cycle, 32'h0);
        check_status("reset", 2'b00, 4'd0, 3'd0);
        reset = 1'b0;

        // No arm: valid samples are ignored
        for (int i = 0; i < 20; i++) sample(32'h100 + 32'(i), 1'b1, 1'b1);
        check_status("idle", 2'b00, 4'd0, 3'd0);
        nrv = 8;
        for (int i = 0; i < 8; i++) rv[i] = '{idx: 3'(i), chan: 4'd0, data: 32'h0, cyc: 32'h0};
        apply_reads("idle");

        // Basic trigger with post_count = 2
        post_count = 3'd2;
        do_arm();
        check_status("armed", 2'b01, 4'd0, 3'd0);
        for (int i = 0; i < 5; i++) sample(32'h10 + 32'(4 * i), 1'b1, i == 4);
        check_status("post", 2'b10, 4'd5, 3'd4);
        sample(32'h24, 1'b1, 1'b0);
        sample(32'h28, 1'b1, 1'b0);
        check_status("basic", 2'b11, 4'd7, 3'd4);
        nrv = 6;
        rv[0] = '{idx: 3'd0, chan: 4'd0, data: 32'h10,   cyc: 32'd0};
        rv[1] = '{idx: 3'd6, chan: 4'd0, data: 32'h28,   cyc: 32'd6};
        rv[2] = '{idx: 3'd4, chan: 4'd1, data: 32'h1020, cyc: 32'd4};
        rv[3] = '{idx: 3'd2, chan: 4'd2, data: 32'h2018, cyc: 32'd2};
        rv[4] = '{idx: 3'd7, chan: 4'd0, data: 32'h0,    cyc: 32'd0};
        rv[5] = '{idx: 3'd0, chan: 4'd3, data: 32'h0,    cyc: 32'd0};
        apply_reads("basic");

        // Wrap-around with post_count = 0, then frozen in DONE
        post_count = 3'd0;
        do_arm();
        for (int i = 1; i <= 12; i++) sample(32'(i), 1'b1, i == 12);
        check_status("wrap", 2'b11, 4'd8, 3'd7);
        sample(32'd99, 1'b1, 1'b0);
        check_status("frozen", 2'b11, 4'd8, 3'd7);
        nrv = 4;
        rv[0] = '{idx: 3'd0, chan: 4'd0, data: 32'd5,     cyc: 32'd4};
        rv[1] = '{idx: 3'd7, chan: 4'd0, data: 32'd12,    cyc: 32'd11};
        rv[2] = '{idx: 3'd3, chan: 4'd2, data: 32'h2008,  cyc: 32'd7};
        rv[3] = '{idx: 3'd5, chan: 4'd1, data: 32'h100a,  cyc: 32'd9};
        apply_reads("wrap");

        // Bubbles: counter keeps running, remaining only drops on valid
        post_count = 3'd2;
        do_arm();
        sample(32'hA0, 1'b1, 1'b0);
        sample(32'hA1, 1'b0, 1'b0);
        sample(32'hA2, 1'b1, 1'b0);
        sample(32'hA3, 1'b0, 1'b0);
        sample(32'hA4, 1'b1, 1'b1);
        sample(32'hA5, 1'b0, 1'b0);
        check_status("bubble1", 2'b10, 4'd3, 3'd2);
        sample(32'hA6, 1'b1, 1'b0);
        sample(32'hA7, 1'b0, 1'b1);
        check_status("bubble2", 2'b10, 4'd4, 3'd2);
        sample(32'hA8, 1'b1, 1'b0);
        check_status("bubble", 2'b11, 4'd5, 3'd2);
        nrv = 4;
        rv[0] = '{idx: 3'd1, chan: 4'd0, data: 32'hA2, cyc: 32'd2};
        rv[1] = '{idx: 3'd2, chan: 4'd0, data: 32'hA4, cyc: 32'd4};
        rv[2] = '{idx: 3'd3, chan: 4'd0, data: 32'hA6, cyc: 32'd6};
        rv[3] = '{idx: 3'd4, chan: 4'd0, data: 32'hA8, cyc: 32'd8};
        apply_reads("bubble");

        // Re-arm mid-POST with trigger on the arm cycle
        post_count = 3'd3;
        do_arm();
        sample(32'hB0, 1'b1, 1'b0);
        sample(32'hB1, 1'b1, 1'b1);
        check_status("prearm", 2'b10, 4'd2, 3'd1);
        arm = 1'b1;
        sample(32'hBF, 1'b1, 1'b1);
        arm = 1'b0;
        check_status("rearm", 2'b01, 4'd0, 3'd0);
        post_count = 3'd0;
        sample(32'hC0, 1'b1, 1'b0);
        sample(32'hC1, 1'b1, 1'b1);
        check_status("retrig", 2'b11, 4'd2, 3'd1);
        nrv = 2;
        rv[0] = '{idx: 3'd0, chan: 4'd0, data: 32'hC0, cyc: 32'd0};
        rv[1] = '{idx: 3'd1, chan: 4'd2, data: 32'h20C1, cyc: 32'd1};
        apply_reads("retrig");

        // Asynchronous reset mid-capture, off the clock edge
        post_count = 3'd5;
        rd_index = 3'd0;
        rd_chan  = 4'd0;
        do_arm();
        sample(32'hD0, 1'b1, 1'b0);
        sample(32'hD1, 1'b1, 1'b1);
        sample(32'hD2, 1'b1, 1'b0);
        check_status("precut", 2'b10, 4'd3, 3'd1);
        #2 reset = 1'b1;
        #1;
        check_status("async", 2'b00, 4'd0, 3'd0);
        check("async.rd_data", rd_data, 32'h0);
        #3 reset = 1'b0;
        tick();
        check_status("postreset", 2'b00, 4'd0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
